block_writer: RTL and testbench

BLOCK_WRITER -- requirements
Module: block_writer

---
 rtl/block_pkg.sv | 14 +
 rtl/block_writer_if.sv | 39 +++
 rtl/beat_counter.sv | 24 ++
 rtl/block_writer.sv | 138 +++++++++++++
 tb/tb_block_writer.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/block_pkg.sv
// Shared constants and the FSM state type for the block write-back path.
package block_pkg;

    localparam int BLOCK_BYTES = 8;
    localparam int ADDR_W      = 16;
    localparam int OFF_W       = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/block_writer_if.sv
// Request / DRAM-write bundle for block_writer.
// Optional macro BLOCK_WRITER_BYTE_MASK_EN adds the per-byte valid mask.
interface block_writer_if #(
    parameter int ADDR_W      = block_pkg::ADDR_W,
    parameter int BLOCK_BYTES = block_pkg::BLOCK_BYTES
);
    localparam int OW = $clog2(BLOCK_BYTES);

    logic                     start;
    logic [8*BLOCK_BYTES-1:0] block_in;
    logic [ADDR_W-OW-1:0]     block_addr;
`ifdef BLOCK_WRITER_BYTE_MASK_EN
    logic [BLOCK_BYTES-1:0]   byte_valid;
`endif
    logic                     ready;
    logic                     done;
    logic                     mem_wr_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic [7:0]               mem_data;

    // Requester side: issues blocks, observes the DRAM write stream.
    modport master (
`ifdef BLOCK_WRITER_BYTE_MASK_EN
        output byte_valid,
`endif
        output start, block_in, block_addr,
        input  ready, done, mem_wr_en, mem_addr, mem_data
    );

    // Writer side.
    modport slave (
`ifdef BLOCK_WRITER_BYTE_MASK_EN
        input  byte_valid,
`endif
        input  start, block_in, block_addr,
        output ready, done, mem_wr_en, mem_addr, mem_data
    );

endinterface

// File: rtl/beat_counter.sv
// Beat counter for block_writer: synchronous clear, count enable and a
// terminal-count flag so the FSM never relies on wrap-around.
module beat_counter #(
    parameter int W    = 4,
    parameter int TERM = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         terminal
);

    // Clear wins over enable; async reset to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + W'(1);
    end

    assign terminal = (count == W'(TERM));

endmodule

// File: rtl/block_writer.sv
// block_writer: writes one cache block to DRAM one byte per cycle.
// Optional macro BLOCK_WRITER_BYTE_MASK_EN: beat k writes only when the
// captured byte_valid[k] is set; address/data still step every beat.
module block_writer #(
    parameter int ADDR_W      = block_pkg::ADDR_W,
    parameter int BLOCK_BYTES = block_pkg::BLOCK_BYTES
) (
    input logic           clk,
    input logic           reset_n,
    block_writer_if.slave bus
);
    import block_pkg::*;

    localparam int OW   = $clog2(BLOCK_BYTES);
    localparam int CW   = OW + 1;
    localparam int BA_W = ADDR_W - OW;

    state_t                   state, state_nxt;
    logic [8*BLOCK_BYTES-1:0] cap_data;
    logic [BA_W-1:0]          cap_addr;
    logic [BLOCK_BYTES-1:0]   cap_mask;
    logic [CW-1:0]            count, cnt_inc;
    logic                     terminal, accept, cnt_en;

    logic              ready_q, done_q, wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              ready_d, done_d, wr_en_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d;
    logic              first_en;

    assign accept  = (state == IDLE) && bus.start;
    assign cnt_en  = (state == WRITE) && !terminal;
    assign cnt_inc = count + CW'(1);

`ifdef BLOCK_WRITER_BYTE_MASK_EN
    logic [BLOCK_BYTES-1:0] in_mask;
    assign in_mask = bus.byte_valid;
`else
    logic [BLOCK_BYTES-1:0] in_mask;
    assign in_mask = '1;
`endif
    assign first_en = in_mask[0];

    // count holds the index of the beat currently on the mem_* outputs
    beat_counter #(.W(CW), .TERM(BLOCK_BYTES - 1)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (accept),
        .enable   (cnt_en),
        .count    (count),
        .terminal (terminal)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: one DONE cycle after the terminal beat, then IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = WRITE;
            WRITE:   if (terminal)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request on acceptance so later input changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_data <= '0;
            cap_addr <= '0;
            cap_mask <= '0;
        end else if (accept) begin
            cap_data <= bus.block_in;
            cap_addr <= bus.block_addr;
            cap_mask <= in_mask;
        end
    end

    // Output next-values; beat 0 comes straight from the inputs at accept,
    // later beats from the captured copies. Addr/data hold otherwise.
    always_comb begin
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        ready_d = (state_nxt == IDLE);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    wr_en_d = first_en;
                    addr_d  = {bus.block_addr, {OW{1'b0}}};
                    data_d  = bus.block_in[7:0];
                end
            end
            WRITE: begin
                if (terminal) begin
                    done_d = 1'b1;
                end else begin
                    wr_en_d = cap_mask[cnt_inc[OW-1:0]];
                    addr_d  = {cap_addr, cnt_inc[OW-1:0]};
                    data_d  = cap_data[8*cnt_inc +: 8];
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            ready_q <= ready_d;
            done_q  <= done_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.mem_wr_en = wr_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_data  = data_q;

endmodule

// File: tb/tb_block_writer.sv
// Directed bench for block_writer at default parameters.
module tb_block_writer;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_err = 0;

    block_writer_if #(.ADDR_W(16), .BLOCK_BYTES(8)) bus ();

    block_writer #(.ADDR_W(16), .BLOCK_BYTES(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are already presented with start=1 before the accepting edge.
    // Walks the 8 beats, the DONE cycle and the IDLE cycle.
    task automatic run_block(input string nm, input logic [12:0] a, input logic [63:0] d,
                             input bit keep_start, input bit scramble, input logic [7:0] mask);
        logic [15:0] ea;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0 && !keep_start) bus.start = 1'b0;
            if (scramble) begin
                bus.block_in   = '0;
                bus.block_addr = '0;
            end
            ea = {a, 3'(k)};
            chk($sformatf("%s wr_en b%0d", nm, k), bus.mem_wr_en, mask[k]);
            chk($sformatf("%s addr b%0d", nm, k), bus.mem_addr, ea);
            chk($sformatf("%s data b%0d", nm, k), bus.mem_data, d[8*k +: 8]);
            chk($sformatf("%s busy b%0d", nm, k), {bus.ready, bus.done}, 2'b00);
        end
        @(negedge clk);
        chk({nm, " done pulse"}, bus.done, 1'b1);
        chk({nm, " done wr_en"}, bus.mem_wr_en, 1'b0);
        chk({nm, " done ready"}, bus.ready, 1'b0);
        chk({nm, " done addr hold"}, bus.mem_addr, {a, 3'd7});
        chk({nm, " done data hold"}, bus.mem_data, d[63:56]);
        @(negedge clk);
        chk({nm, " idle ready"}, bus.ready, 1'b1);
        chk({nm, " idle done"}, bus.done, 1'b0);
        chk({nm, " idle wr_en"}, bus.mem_wr_en, 1'b0);
    endtask

    task automatic present(input logic [12:0] a, input logic [63:0] d, input logic [7:0] mask);
        bus.start      = 1'b1;
        bus.block_addr = a;
        bus.block_in   = d;
`ifdef BLOCK_WRITER_BYTE_MASK_EN
        bus.byte_valid = mask;
`else
        if (mask != 8'hFF) $display("note: mask ignored in this build");
`endif
    endtask

    initial begin
        bit stray;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.block_addr = '0;
        bus.block_in   = '0;
`ifdef BLOCK_WRITER_BYTE_MASK_EN
        bus.byte_valid = '0;
`endif
        @(negedge clk);
        chk("rst ready", bus.ready, 1'b1);
        chk("rst done", bus.done, 1'b0);
        chk("rst wr_en", bus.mem_wr_en, 1'b0);
        chk("rst addr", bus.mem_addr, 16'h0000);
        chk("rst data", bus.mem_data, 8'h00);

        // First start offered together with reset release.
        @(negedge clk);
        reset_n = 1'b1;
        present(13'h0123, 64'h8877665544332211, 8'hFF);
        run_block("basic", 13'h0123, 64'h8877665544332211, 1'b0, 1'b0, 8'hFF);

        // Start held high across two blocks.
        present(13'h0040, 64'h0807060504030201, 8'hFF);
        run_block("b2b_a", 13'h0040, 64'h0807060504030201, 1'b1, 1'b0, 8'hFF);
        present(13'h0041, 64'hF0E0D0C0B0A09080, 8'hFF);
        run_block("b2b_b", 13'h0041, 64'hF0E0D0C0B0A09080, 1'b0, 1'b0, 8'hFF);

        // Inputs zeroed while writing.
        present(13'h0A5A, 64'hDEADBEEFCAFEF00D, 8'hFF);
        run_block("capture", 13'h0A5A, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b1, 8'hFF);

        // Top of the address space.
        present(13'h1FFF, 64'h0123456789ABCDEF, 8'hFF);
        run_block("top_addr", 13'h1FFF, 64'h0123456789ABCDEF, 1'b0, 1'b0, 8'hFF);

`ifdef BLOCK_WRITER_BYTE_MASK_EN
        present(13'h0200, 64'h7766554433221100, 8'hA5);
        run_block("mask", 13'h0200, 64'h7766554433221100, 1'b0, 1'b0, 8'hA5);
`endif

        // Reset during beat 3.
        present(13'h0300, 64'h1111111111111111, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("mid b3 wr_en", bus.mem_wr_en, 1'b1);
        chk("mid b3 addr", bus.mem_addr, 16'h1803);
        #2 reset_n = 1'b0;
        #1;
        chk("mid rst wr_en", bus.mem_wr_en, 1'b0);
        chk("mid rst ready", bus.ready, 1'b1);
        chk("mid rst addr", bus.mem_addr, 16'h0000);
        chk("mid rst data", bus.mem_data, 8'h00);
        stray = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.mem_wr_en) stray = 1'b1;
        end
        chk("abandoned no writes", stray, 1'b0);
        chk("abandoned ready", bus.ready, 1'b1);

        // Clean block after the interrupted one.
        present(13'h0007, 64'hA1B2C3D4E5F60718, 8'hFF);
        run_block("recover", 13'h0007, 64'hA1B2C3D4E5F60718, 1'b0, 1'b0, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
